// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and line levels.
// Used by both the transmit and receive sides.
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Counter width that still holds n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Transmit request/serial-line bundle between a word source and the UART transmitter.
interface uart_tx_fsm_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx;
  logic             tx_busy;
  logic             tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks while enabled and flags the
// last clock of every period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = enable && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, WIDTH data bits LSB first, parity, stop bit.
// Every output is a register; tx trails the state by one clock.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fsm_if.slave   bus
);

  localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e      state;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic             par_bit;
  logic             stop_q;
  logic             bit_end;
  logic             accept_c;
  logic             tx_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;

  assign accept_c = (state == IDLE) && ready_r && bus.tx_valid;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_c),
    .enable  (state != IDLE),
    .bit_end (bit_end)
  );

  assign bus.tx       = tx_r;
  assign bus.tx_ready = ready_r;
  assign bus.tx_busy  = busy_r;
  assign bus.tx_done  = done_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= PAR_EVEN;
      stop_q  <= 1'b0;
      tx_r    <= LINE_IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      // done lines up with the first idle level on tx after the stop bit
      stop_q <= (state == STOP);
      done_r <= (state == IDLE) && stop_q;
      case (state)
        IDLE: begin
          tx_r <= LINE_IDLE;
          if (accept_c) begin
            shreg   <= bus.tx_data;
            par_bit <= (^bus.tx_data) ^ PAR_MODE;
            bit_cnt <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          tx_r <= START_BIT;
          if (bit_end) state <= DATA;
        end
        DATA: begin
          tx_r <= shreg[0];
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) state <= PARITY;
          end
        end
        PARITY: begin
          tx_r <= par_bit;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          tx_r <= LINE_IDLE;
          if (bit_end) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          tx_r    <= LINE_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
